// File: rtl/load_store_unit.sv
// Load/store unit: turns one RV32I byte-addressed load/store into word-indexed memory cycles.
// Latency: aligned store completes at accept; load result 1 cycle after accept (2 if split).
// Backpressure: req_ready high only in IDLE; low during split second cycle and load response.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_we, funct3, addr, wdata sampled at accept only
//   resp_valid, rdata     - one-cycle load response, rdata is 0 whenever resp_valid is 0
//   mem_we/be/addr/wd     - word-indexed memory port, byte enables, lane-shifted write data
//   mem_rd                - registered memory read data (valid the cycle after the address)
module load_store_unit #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       addr,
  input  logic [XLEN-1:0]       wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       rdata,
  output logic                  mem_we,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wd,
  input  logic [XLEN-1:0]       mem_rd
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LRESP = 2'd1,
    RD2   = 2'd2,
    WR2   = 2'd3
  } state_t;

  state_t state;

  // Request decode (only meaningful in the accept cycle)
  logic                  legal;
  logic [2*NB-1:0]       size_mask;
  logic [2*NB-1:0]       byte_mask;
  logic [2*XLEN-1:0]     sized_wd;
  logic [2*XLEN-1:0]     store_lanes;
  logic                  is_split;
  logic [ADDR_WIDTH-1:0] word_a;
  logic                  accept;

  // State carried from the accept cycle into WR2 / RD2 / LRESP
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  illegal_q;
  logic                  split_q;
  logic [ADDR_WIDTH-1:0] addr2_q;
  logic [NB-1:0]         be2_q;
  logic [XLEN-1:0]       wd2_q;
  logic [XLEN-1:0]       lo_buf;

  // Load result path
  logic [2*XLEN-1:0]     combined;
  logic [2*XLEN-1:0]     shifted;
  logic [XLEN-1:0]       load_result;

  always_comb begin
    legal     = 1'b1;
    size_mask = '0;
    sized_wd  = '0;
    unique case (funct3)
      3'b000, 3'b100: begin
        size_mask = (2*NB)'(8'h01);
        sized_wd  = {{(2*XLEN-8){1'b0}}, wdata[7:0]};
      end
      3'b001, 3'b101: begin
        size_mask = (2*NB)'(8'h03);
        sized_wd  = {{(2*XLEN-16){1'b0}}, wdata[15:0]};
      end
      3'b010: begin
        size_mask = (2*NB)'(8'h0F);
        sized_wd  = {{XLEN{1'b0}}, wdata};
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal funct3 yields an empty mask, so it can never be split or write.
  assign byte_mask   = size_mask << addr[1:0];
  assign store_lanes = sized_wd << {addr[1:0], 3'b000};
  assign is_split    = |byte_mask[2*NB-1:NB];
  assign word_a      = addr[ADDR_WIDTH+1:2];
  assign accept      = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      off_q     <= '0;
      f3_q      <= '0;
      illegal_q <= 1'b0;
      split_q   <= 1'b0;
      addr2_q   <= '0;
      be2_q     <= '0;
      wd2_q     <= '0;
      lo_buf    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            off_q     <= addr[1:0];
            f3_q      <= funct3;
            illegal_q <= ~legal;
            split_q   <= is_split;
            // Second word wraps naturally at the top of the word space
            addr2_q   <= word_a + ADDR_WIDTH'(1);
            be2_q     <= byte_mask[2*NB-1:NB];
            wd2_q     <= store_lanes[2*XLEN-1:XLEN];
            if (req_we)
              state <= is_split ? WR2 : IDLE;
            else
              state <= is_split ? RD2 : LRESP;
          end
        end
        WR2: state <= IDLE;
        RD2: begin
          // mem_rd now holds word A, read during the accept cycle
          lo_buf <= mem_rd;
          state  <= LRESP;
        end
        LRESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // In LRESP mem_rd holds word A (aligned) or word A+1 (split, low half in lo_buf).
  always_comb begin
    combined    = split_q ? {mem_rd, lo_buf} : {{XLEN{1'b0}}, mem_rd};
    shifted     = combined >> {off_q, 3'b000};
    load_result = '0;
    if (!illegal_q) begin
      unique case (f3_q)
        3'b000:  load_result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
        3'b001:  load_result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        3'b010:  load_result = shifted[XLEN-1:0];
        3'b100:  load_result = {{(XLEN-8){1'b0}}, shifted[7:0]};
        3'b101:  load_result = {{(XLEN-16){1'b0}}, shifted[15:0]};
        default: load_result = '0;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    rdata      = '0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wd     = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          mem_addr = word_a;
          mem_be   = byte_mask[NB-1:0];
          if (req_we) begin
            mem_wd = store_lanes[XLEN-1:0];
            mem_we = legal && !reset;
          end
        end
      end
      WR2: begin
        mem_addr = addr2_q;
        mem_be   = be2_q;
        mem_wd   = wd2_q;
        // Reset during the second half leaves only the first half written
        mem_we   = !reset;
      end
      RD2: begin
        mem_addr = addr2_q;
      end
      LRESP: begin
        resp_valid = !reset;
        rdata      = reset ? '0 : load_result;
      end
      default: ;
    endcase
  end

  // Address bits above the memory index are ignored by design
  logic unused_ok;
  assign unused_ok = ^{addr[XLEN-1:ADDR_WIDTH+2], shifted[2*XLEN-1:XLEN]};

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-level reference memory, port-level expectations per
// request, and a scoreboard monitor that checks every load response and its timing.
module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int AW   = 8;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      funct3;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            resp_valid;
  logic [31:0]     rdata;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wd;
  logic [31:0]     mem_rd;

  load_store_unit #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory attached to the DUT, registered read
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
    mem_rd <= mem[mem_addr];
  end

  // Reference: flat byte-addressed memory of 1024 bytes (little endian)
  logic [7:0] refb [1024];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sz(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v;
    int n;
    int base;
    v = 0;
    n = sz(f);
    base = int'(a[9:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = refb[(base + i) % 1024];
    if (f == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // first_only: only the bytes that land in the first word are written
  task automatic ref_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                           input bit first_only);
    int n;
    int base;
    n = sz(f);
    base = int'(a[9:0]);
    for (int i = 0; i < n; i++)
      if (!first_only || (int'(a[1:0]) + i) < 4)
        refb[(base + i) % 1024] = d[8*i +: 8];
  endtask

  // Monitor: every response must match the head of the scoreboard, in the expected cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_resp expected in cycle %0d data %h", e.cyc, e.data);
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual rdata=%h required none (cycle %0d)", rdata, cyc);
      end else begin
        e = sb.pop_front();
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
        check("rdata", 64'(rdata), 64'(e.data));
      end
    end else begin
      check("rdata_idle_zero", 64'(rdata), 64'd0);
    end
  end

  // Issue one request; rst2 asserts reset during the second cycle of a split access.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit rst2);
    int n, o, w, p, waited, acc;
    logic [3:0]  be1, be2;
    logic [31:0] wd1, wd2;
    bit split;
    exp_t e;
    n = sz(f3);
    o = int'(a[1:0]);
    w = int'(a[9:2]);
    be1 = 0; be2 = 0; wd1 = 0; wd2 = 0;
    for (int i = 0; i < n; i++) begin
      p = o + i;
      if (p < 4) begin
        be1[p] = 1'b1;
        wd1[8*p +: 8] = wd[8*i +: 8];
      end else begin
        be2[p-4] = 1'b1;
        wd2[8*(p-4) +: 8] = wd[8*i +: 8];
      end
    end
    split = (o + n) > 4;

    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual req_ready=0 required 1 within 10 cycles");
      return;
    end
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    #1;
    acc = cyc;
    check("acc_addr", 64'(mem_addr), 64'(w));
    check("acc_be", 64'(mem_be), 64'(be1));
    check("acc_we", 64'(mem_we), 64'(we && n > 0));
    if (we) check("acc_wd", 64'(mem_wd), 64'(wd1));

    @(posedge clk);
    #1;
    // Inputs are only sampled at accept; scramble them afterwards
    req_valid = 1'b0;
    req_we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;

    if (we) begin
      ref_store(f3, a, wd, rst2 && split);
      if (split) begin
        check("wr2_addr", 64'(mem_addr), 64'((w + 1) % 256));
        check("wr2_be", 64'(mem_be), 64'(be2));
        check("wr2_wd", 64'(mem_wd), 64'(wd2));
        check("wr2_ready", 64'(req_ready), 64'd0);
        if (rst2) begin
          reset = 1'b1;
          #1;
          check("wr2_reset_we", 64'(mem_we), 64'd0);
        end else begin
          check("wr2_we", 64'(mem_we), 64'd1);
        end
      end else begin
        check("store_ready", 64'(req_ready), 64'd1);
      end
    end else begin
      check("load_busy", 64'(req_ready), 64'd0);
      if (split) begin
        check("rd2_addr", 64'(mem_addr), 64'((w + 1) % 256));
        check("rd2_we", 64'(mem_we), 64'd0);
      end
      if (rst2 && split) begin
        reset = 1'b1;
      end else begin
        e.data = ref_load(f3, a);
        e.cyc  = acc + (split ? 2 : 1);
        sb.push_back(e);
      end
    end

    if (reset) begin
      @(posedge clk);
      #1;
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_resp", 64'(resp_valid), 64'd0);
      reset = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
    addr = 32'h0000_0006; wdata = $urandom;
    for (int i = 0; i < n; i++) begin
      #1;
      check("reset_we", 64'(mem_we), 64'd0);
      check("reset_ready", 64'(req_ready), 64'd1);
      check("reset_resp", 64'(resp_valid), 64'd0);
      check("reset_rdata", 64'(rdata), 64'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    req_valid = 1'b0;
  endtask

  logic [2:0] f3_tbl [10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                              3'b000, 3'b010, 3'b100, 3'b011, 3'b111};

  initial begin
    logic [31:0] a;
    logic [31:0] word;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
    addr = 0; wdata = 0;
    for (int i = 0; i < 1024; i++) refb[i] = 8'($urandom);
    for (int w = 0; w < 256; w++)
      mem[w] = {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};

    do_reset(2);

    // Aligned word, byte store/load with sign and zero extension
    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0);
    issue(1, 3'b000, 32'h13, 32'h5A, 0);
    issue(0, 3'b000, 32'h13, 32'h0, 0);
    issue(1, 3'b000, 32'h13, 32'hF0, 0);
    issue(0, 3'b000, 32'h13, 32'h0, 0);
    issue(0, 3'b100, 32'h13, 32'h0, 0);

    // Split accesses
    issue(1, 3'b010, 32'h06, 32'h11223344, 0);
    issue(0, 3'b010, 32'h06, 32'h0, 0);
    issue(0, 3'b001, 32'h07, 32'h0, 0);

    // Word-index wrap and illegal funct3
    issue(1, 3'b001, 32'h3FF, 32'h0000BEEF, 0);
    issue(0, 3'b101, 32'h3FF, 32'h0, 0);
    issue(0, 3'b011, 32'h20, 32'h0, 0);
    issue(1, 3'b111, 32'h24, 32'hCAFEF00D, 0);
    issue(0, 3'b010, 32'h24, 32'h0, 0);

    // Back-to-back aligned stores, then read them back
    for (int i = 0; i < 4; i++) issue(1, 3'b010, 32'h40 + 4*i, $urandom, 0);
    for (int i = 0; i < 4; i++) issue(0, 3'b010, 32'h40 + 4*i, 32'h0, 0);

    // Reset during the second cycle of split load and split store
    issue(0, 3'b010, 32'h06, 32'h0, 1);
    issue(1, 3'b010, 32'h0E, 32'hA1B2C3D4, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 0);
    issue(0, 3'b001, 32'h0E, 32'h0, 0);

    // Randomized traffic around the wrap point, with random ignored upper address bits
    for (int i = 0; i < 400; i++) begin
      a = ($urandom & 32'hFFFF_FC00) | 32'(($urandom_range(0, 63) + 1000) % 1024);
      issue(1'($urandom), f3_tbl[$urandom_range(0, 9)], a, $urandom, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    for (int w = 0; w < 256; w++) begin
      word = {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
      check("mem_contents", 64'(mem[w]), 64'(word));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
